// File: rtl/uart_tb_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tb_tx
// Purpose  : Clocked UART transmitter for bench use. Bytes enter a small FIFO
//            over a valid/ready port and leave as LSB-first frames: a start
//            bit, 8 data bits, an optional even-parity bit, then 1 or 2 stop
//            bits. Every bit lasts a runtime-programmable number of clocks.
// Ports    : clk_i        - bench clock
//            rstn_i       - synchronous active-low reset
//            cfg_div_i    - clocks per UART bit (0 behaves as 1)
//            tx_en_i      - allows new frames to start
//            data_i       - byte to queue, accepted on valid_i && ready_o
//            valid_i      - data_i valid
//            ready_o      - FIFO not full (registered)
//            tx_o         - serial line, idle high
//            busy_o       - a frame is in progress
//            frame_done_o - one-cycle pulse at the end of the last stop bit
//            fifo_level_o - bytes currently queued
// Revision : 1.0 - initial release
// ============================================================================
module uart_tb_tx #(
   parameter int ID         = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_EN  = 1,
   parameter int STOP_BITS  = 1
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic [15:0]                 cfg_div_i,
   input  logic                        tx_en_i,
   input  logic [7:0]                  data_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   output logic                        tx_o,
   output logic                        busy_o,
   output logic                        frame_done_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   c_lvl_one = (AW+1)'(1);
   localparam logic [AW:0]   c_full    = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] c_ptr_one = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_ready;

   // Serialiser state
   state_t        r_state;
   logic [7:0]    r_shift;
   logic          r_par;
   logic [15:0]   r_div;
   logic [15:0]   r_cnt;
   logic [2:0]    r_idx;
   logic          r_stop;
   logic          r_tx;
   logic          r_busy;
   logic          r_done;

   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_start_ok;
   logic [7:0]    w_head;
   logic [15:0]   w_cfg_div;
   logic          w_bit_end;
   logic          w_stop_last;
   logic [AW:0]   w_level_next;

   state_t        w_state_next;
   logic          w_done;
   logic [7:0]    w_shift_next;
   logic          w_par_next;
   logic [15:0]   w_div_next;
   logic [15:0]   w_cnt_next;
   logic [2:0]    w_idx_next;
   logic          w_stop_next;
   logic          w_tx_next;

   assign w_push      = valid_i && r_ready;
   assign w_empty     = (r_level == '0);
   assign w_start_ok  = !w_empty && tx_en_i;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_cfg_div   = (cfg_div_i == 16'd0) ? 16'd1 : cfg_div_i;
   // The bit counter runs from div-1 down to 0; zero marks the last cycle of a bit.
   assign w_bit_end   = (r_cnt == 16'd0);
   assign w_stop_last = (STOP_BITS == 1) ? 1'b1 : r_stop;

   always_comb begin
      w_level_next = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_next = r_level + c_lvl_one;
         2'b01:   w_level_next = r_level - c_lvl_one;
         default: w_level_next = r_level;
      endcase
   end

   // Next-state and datapath decode
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_done       = 1'b0;
      w_shift_next = r_shift;
      w_par_next   = r_par;
      w_div_next   = r_div;
      w_cnt_next   = w_bit_end ? (r_div - 16'd1) : (r_cnt - 16'd1);
      w_idx_next   = r_idx;
      w_stop_next  = r_stop;
      w_tx_next    = 1'b1;

      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_state_next = S_START;
               w_pop        = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_next = S_DATA;
               w_idx_next   = 3'd0;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_idx == 3'd7) begin
                  w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  w_stop_next  = 1'b0;
               end else begin
                  w_idx_next   = r_idx + 3'd1;
                  w_shift_next = {1'b0, r_shift[7:1]};
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_next = S_STOP;
               w_stop_next  = 1'b0;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (w_stop_last) begin
                  w_done = 1'b1;
                  // Back-to-back: a waiting byte starts on the very next cycle.
                  if (w_start_ok) begin
                     w_state_next = S_START;
                     w_pop        = 1'b1;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end else begin
                  w_stop_next = 1'b1;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // A pop loads a fresh frame; the divider is frozen here for the whole frame.
      if (w_pop) begin
         w_shift_next = w_head;
         w_par_next   = ^w_head;
         w_div_next   = w_cfg_div;
         w_cnt_next   = w_cfg_div - 16'd1;
      end

      // Line value is registered, so it is derived from the state being entered.
      case (w_state_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_shift_next[0];
         S_PARITY: w_tx_next = w_par_next;
         default:  w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_ready  <= 1'b1;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_div    <= 16'd1;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_stop   <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
         r_level <= w_level_next;
         // No push-through when full: ready only rises after the pop lands.
         r_ready <= (w_level_next != c_full);
         r_shift <= w_shift_next;
         r_par   <= w_par_next;
         r_div   <= w_div_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_stop  <= w_stop_next;
         r_tx    <= w_tx_next;
         r_busy  <= (w_state_next != S_IDLE);
         r_done  <= w_done;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rstn_i && w_pop) $display("[%0d] TX byte: %h", ID, w_head);
   end
`endif

   assign ready_o      = r_ready;
   assign tx_o         = r_tx;
   assign busy_o       = r_busy;
   assign frame_done_o = r_done;
   assign fifo_level_o = r_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tb_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tb_tx
// Purpose  : Bench for uart_tb_tx. Two instances: u0 with even parity and one
//            stop bit, u1 without parity and with two stop bits. Every byte
//            sent is paired with its expected divider in a queue; a monitor
//            captures each frame on the line and compares it, sample by
//            sample, against the frame rebuilt from that byte and divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tb_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [15:0] cfg0, cfg1;
   logic        en0, en1, v0, v1;
   logic [7:0]  d0, d1;
   logic        rdy0, tx0, busy0, done0;
   logic        rdy1, tx1, busy1, done1;
   logic [2:0]  lvl0, lvl1;

   uart_tb_tx #(.ID(0), .FIFO_DEPTH(4), .PARITY_EN(1), .STOP_BITS(1)) u0 (
      .clk_i(clk), .rstn_i(rstn), .cfg_div_i(cfg0), .tx_en_i(en0),
      .data_i(d0), .valid_i(v0), .ready_o(rdy0), .tx_o(tx0),
      .busy_o(busy0), .frame_done_o(done0), .fifo_level_o(lvl0));

   uart_tb_tx #(.ID(1), .FIFO_DEPTH(4), .PARITY_EN(0), .STOP_BITS(2)) u1 (
      .clk_i(clk), .rstn_i(rstn), .cfg_div_i(cfg1), .tx_en_i(en1),
      .data_i(d1), .valid_i(v1), .ready_o(rdy1), .tx_o(tx1),
      .busy_o(busy1), .frame_done_o(done1), .fifo_level_o(lvl1));

   typedef struct {
      logic [7:0] b;
      int         div;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Monitor capture state, one slot per instance
   logic smp [2][4096];
   int   mlen [2];
   bit   mcoll [2];
   bit   mbusy_bad [2];
   int   n_done [2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   // Expected line level for sample idx of a frame carrying byte b.
   function automatic logic exp_bit(input int k, input logic [7:0] b, input int div, input int idx);
      int pos;
      pos = idx / div;
      if (pos == 0) return 1'b0;
      if (pos <= 8) return b[pos-1];
      if (k == 0 && pos == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic int frame_len(input int k, input int div);
      int pe, st;
      pe = (k == 0) ? 1 : 0;
      st = (k == 0) ? 1 : 2;
      return (10 + pe + st - 1) * div;
   endfunction

   task automatic frame_check(input int k);
      exp_t e;
      int   want, bad;
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected frame on u%0d: got %0d samples, want no frame", k, mlen[k]);
         return;
      end
      e    = (k == 0) ? q0.pop_front() : q1.pop_front();
      want = frame_len(k, e.div);
      bad  = -1;
      if (mlen[k] != want) begin
         bad = mlen[k];
      end else begin
         for (int i = 0; i < want; i++) begin
            if (bad < 0 && smp[k][i] !== exp_bit(k, e.b, e.div, i)) bad = i;
         end
      end
      n_cmp++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL frame u%0d byte %h div %0d: got %0d samples (first bad sample %0d), want %0d matching samples",
                  k, e.b, e.div, mlen[k], bad, want);
      end
      chk($sformatf("busy during frame u%0d byte %h", k, e.b), {31'd0, mbusy_bad[k]}, 32'd0);
   endtask

   task automatic mon_step(input int k, input logic tx, input logic done, input logic busy, input logic rst);
      if (!rst) begin
         mcoll[k] = 1'b0;
         return;
      end
      if (done) n_done[k]++;
      if (mcoll[k]) begin
         if (done) begin
            frame_check(k);
            mcoll[k] = (tx == 1'b0);
            mlen[k]  = 0;
            if (tx == 1'b0) begin
               smp[k][0]    = 1'b0;
               mlen[k]      = 1;
               mbusy_bad[k] = !busy;
            end
         end else begin
            if (mlen[k] < 4096) smp[k][mlen[k]] = tx;
            mlen[k]++;
            if (!busy) mbusy_bad[k] = 1'b1;
         end
      end else if (done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL stray frame_done on u%0d: got pulse, want none", k);
      end else if (tx == 1'b0) begin
         mcoll[k]     = 1'b1;
         smp[k][0]    = 1'b0;
         mlen[k]      = 1;
         mbusy_bad[k] = !busy;
      end
   endtask

   always @(negedge clk) begin
      mon_step(0, tx0, done0, busy0, rstn);
      mon_step(1, tx1, done1, busy1, rstn);
   end

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic push(input int k, input logic [7:0] b, input int div, input bit expect_it);
      int  w;
      exp_t e;
      w = 0;
      if (k == 0) begin d0 = b; v0 = 1'b1; end
      else        begin d1 = b; v1 = 1'b1; end
      while (((k == 0) ? rdy0 : rdy1) !== 1'b1 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         n_cmp++;
         n_fail++;
         $display("FAIL push timeout u%0d byte %h: got ready low, want accept", k, b);
      end
      @(negedge clk);
      v0 = 1'b0;
      v1 = 1'b0;
      e.b   = b;
      e.div = div;
      if (expect_it) begin
         if (k == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic wait_idle(input int k);
      int w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(((k == 0) ? q0.size() : q1.size()) == 0 &&
                   ((k == 0) ? busy0 : busy1) == 1'b0 &&
                   ((k == 0) ? lvl0 : lvl1) == 3'd0) && w < 3000);
      if (w >= 3000) begin
         n_cmp++;
         n_fail++;
         $display("FAIL idle timeout u%0d: got still busy, want idle", k);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, tstart, nd, low;

      rstn = 1'b0;
      cfg0 = 16'd4; cfg1 = 16'd3;
      en0 = 1'b1;   en1 = 1'b1;
      v0 = 1'b0;    v1 = 1'b0;
      d0 = 8'h00;   d1 = 8'h00;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Reset state
      chk("reset tx0", {31'd0, tx0}, 32'd1);
      chk("reset busy0", {31'd0, busy0}, 32'd0);
      chk("reset done0", {31'd0, done0}, 32'd0);
      chk("reset level0", {29'd0, lvl0}, 32'd0);
      chk("reset ready0", {31'd0, rdy0}, 32'd1);
      chk("reset tx1", {31'd0, tx1}, 32'd1);

      // 0x55 at 4 clocks per bit, then 0x07 at 2 clocks per bit
      push(0, 8'h55, 4, 1'b1);
      wait_idle(0);
      cfg0 = 16'd2;
      push(0, 8'h07, 2, 1'b1);
      wait_idle(0);

      // Fill the FIFO with transmission disabled
      en0 = 1'b0;
      for (int i = 1; i <= 4; i++) push(0, 8'(i), 2, 1'b1);
      chk("full level", {29'd0, lvl0}, 32'd4);
      chk("full ready", {31'd0, rdy0}, 32'd0);
      d0 = 8'h05;
      v0 = 1'b1;
      repeat (3) @(negedge clk);
      chk("no push while full: ready", {31'd0, rdy0}, 32'd0);
      chk("no push while full: level", {29'd0, lvl0}, 32'd4);
      begin
         exp_t e;
         e.b = 8'h05; e.div = 2;
         q0.push_back(e);
      end
      en0 = 1'b1;
      fork
         begin
            int w;
            w = 0;
            while (rdy0 !== 1'b1 && w < 100) begin
               @(negedge clk);
               w++;
            end
            chk("ready rises one cycle after first pop", w, 1);
            @(negedge clk);
            v0 = 1'b0;
         end
         begin
            t = 0; tstart = -1; nd = 0;
            while (nd < 5 && t < 600) begin
               @(negedge clk);
               t++;
               if (tstart < 0 && tx0 == 1'b0) tstart = t;
               if (done0) nd++;
            end
            chk("five back-to-back frames cycles", t - tstart, 110);
            chk("frame_done pulses", nd, 5);
         end
      join
      wait_idle(0);

      // Divider change mid-frame only affects the next frame; 0 means 1
      cfg0 = 16'd4;
      push(0, 8'hA3, 4, 1'b1);
      push(0, 8'h3C, 8, 1'b1);
      repeat (6) @(negedge clk);
      cfg0 = 16'd8;
      wait_idle(0);
      cfg0 = 16'd0;
      push(0, 8'h96, 1, 1'b1);
      wait_idle(0);

      // Reset during data bit 3 of 0xC5 with a second byte still queued
      cfg0 = 16'd4;
      push(0, 8'hC5, 4, 1'b0);
      push(0, 8'h3A, 4, 1'b0);
      t = 0;
      while (tx0 !== 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("start bit seen before reset", {31'd0, tx0}, 32'd0);
      repeat (17) @(negedge clk);
      chk("line low in data bit 3", {31'd0, tx0}, 32'd0);
      rstn = 1'b0;
      @(negedge clk);
      chk("abort tx", {31'd0, tx0}, 32'd1);
      chk("abort level", {29'd0, lvl0}, 32'd0);
      chk("abort busy", {31'd0, busy0}, 32'd0);
      chk("abort done", {31'd0, done0}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      low = 0; nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx0 == 1'b0) low++;
         if (done0) nd++;
      end
      chk("no spurious start after reset", low, 0);
      chk("no frame_done after abort", nd, 0);

      // Two stop bits, no parity
      cfg1 = 16'd3;
      push(1, 8'hFF, 3, 1'b1);
      wait_idle(1);

      chk("u0 expected frames drained", q0.size(), 0);
      chk("u1 expected frames drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
